// File: rtl/uart_pkg.sv
// uart_pkg: shared parity modes, receiver state encoding and parity helper
package uart_pkg;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
  function automatic logic parity_calc(input logic [8:0] d, input logic [1:0] mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with explicit level counter
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_rd, do_wr;
  assign empty = level == '0;
  assign full = level == (AW+1)'(DEPTH);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      level <= level + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wr_data;
  end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART receiver that checks each frame and captures good characters into a FIFO
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);
  localparam int CW = $clog2(CLK_DIV);
  rx_state_t state;
  logic s1, s2, rxs_d;
  logic [CW-1:0] cnt;
  logic [3:0] nbit;
  logic [DATA_BITS-1:0] sh;
  logic perr_f, ferr_f;
  logic tick, last_stop, bad_frame, good, push, ovr;
  assign tick = cnt == '0;
  assign last_stop = state == S_STOP && tick && nbit == 4'(STOP_BITS-1);
  assign bad_frame = ferr_f | ~s2;
  assign good = last_stop && !bad_frame && !perr_f;
  // a full FIFO still accepts the character when the consumer pops in the same cycle
  assign push = good && (!full || rd_en);
  assign ovr = good && full && !rd_en;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      rxs_d <= 1'b1;
      state <= S_IDLE;
      cnt <= '0;
      nbit <= '0;
      sh <= '0;
      perr_f <= 1'b0;
      ferr_f <= 1'b0;
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      rxs_d <= s2;
      frame_err <= last_stop && bad_frame;
      parity_err <= last_stop && !bad_frame && perr_f;
      overrun <= ovr | (overrun & ~clr_err);
      if (state != S_IDLE) cnt <= tick ? CW'(CLK_DIV-1) : cnt - 1'b1;
      case (state)
        S_IDLE: if (rxs_d && !s2) begin
          state <= S_START;
          cnt <= CW'(CLK_DIV/2-1);
          nbit <= '0;
          perr_f <= 1'b0;
          ferr_f <= 1'b0;
        end
        S_START: if (tick) state <= s2 ? S_IDLE : S_DATA;
        S_DATA: if (tick) begin
          sh <= {s2, sh[DATA_BITS-1:1]};
          nbit <= (nbit == 4'(DATA_BITS-1)) ? '0 : nbit + 1'b1;
          if (nbit == 4'(DATA_BITS-1)) state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
        S_PARITY: if (tick) begin
          perr_f <= s2 != parity_calc(9'(sh), 2'(PARITY_MODE));
          state <= S_STOP;
        end
        S_STOP: if (tick) begin
          ferr_f <= ferr_f | ~s2;
          nbit <= nbit + 1'b1;
          if (last_stop) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(sh),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .empty(empty),
    .full(full),
    .level(level)
  );
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: scoreboard bench for an 8N1 depth-4 receiver and an 8E1 receiver
module tb_uart_rx_capture;
  logic clk = 1'b0, rst = 1'b1;
  logic rxd_a = 1'b1, rxd_b = 1'b1, rd_a = 1'b0, rd_b = 1'b0, clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a, data_b;
  logic empty_a, full_a, fe_a, pe_a, ov_a;
  logic empty_b, full_b, fe_b, pe_b, ov_b;
  logic [2:0] level_a;
  logic [3:0] level_b;
  int n_chk = 0, n_fail = 0;
  logic [7:0] dq_a[$], dq_b[$];
  logic [31:0] eq_a[$], eq_b[$];
  uart_rx_capture #(.FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rxd(rxd_a), .rd_en(rd_a), .clr_err(clr_a),
    .rd_data(data_a), .empty(empty_a), .full(full_a), .level(level_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));
  uart_rx_capture #(.PARITY_MODE(1)) u_b (
    .clk(clk), .rst(rst), .rxd(rxd_b), .rd_en(rd_b), .clr_err(clr_b),
    .rd_data(data_b), .empty(empty_b), .full(full_b), .level(level_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (fe_a || pe_a) begin
        if (eq_a.size() == 0) check("err_a_unexpected", 32'({pe_a, fe_a}), 0);
        else check("err_a_kind", 32'({pe_a, fe_a}), eq_a.pop_front());
      end
      if (fe_b || pe_b) begin
        if (eq_b.size() == 0) check("err_b_unexpected", 32'({pe_b, fe_b}), 0);
        else check("err_b_kind", 32'({pe_b, fe_b}), eq_b.pop_front());
      end
      if (rd_a && !empty_a) begin
        if (dq_a.size() == 0) check("read_a_unexpected", 32'(data_a), 32'hffff_ffff);
        else check("read_a_data", 32'(data_a), 32'(dq_a.pop_front()));
      end
      if (rd_b && !empty_b) begin
        if (dq_b.size() == 0) check("read_b_unexpected", 32'(data_b), 32'hffff_ffff);
        else check("read_b_data", 32'(data_b), 32'(dq_b.pop_front()));
      end
    end
  end
  task automatic put(input bit b, input logic v);
    @(posedge clk);
    #1;
    if (b) rxd_b = v;
    else rxd_a = v;
    repeat (15) @(posedge clk);
  endtask
  task automatic send(input bit b, input logic [7:0] d, input int par, input logic stp);
    put(b, 1'b0);
    for (int i = 0; i < 8; i++) put(b, d[i]);
    if (par >= 0) put(b, par[0]);
    put(b, stp);
    put(b, 1'b1);
    repeat (4) @(posedge clk);
  endtask
  task automatic read(input bit b);
    @(posedge clk);
    #1;
    if (b) rd_b = 1'b1;
    else rd_a = 1'b1;
    @(posedge clk);
    #1;
    rd_a = 1'b0;
    rd_b = 1'b0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_empty", 32'(empty_a), 1);
    check("rst_level", 32'(level_a), 0);
    check("rst_rd_data", 32'(data_a), 0);
    check("rst_overrun", 32'(ov_a), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    dq_a.push_back(8'hA5);
    fork
      send(0, 8'hA5, -1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        check("a5_empty_before_push", 32'(empty_a), 1);
        @(posedge clk);
        @(negedge clk);
        check("a5_empty_after_push", 32'(empty_a), 0);
        check("a5_rd_data", 32'(data_a), 32'hA5);
        check("a5_level", 32'(level_a), 1);
        check("a5_no_err", 32'({fe_a, pe_a}), 0);
      end
    join
    read(0);
    @(posedge clk);
    #1 rxd_a = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("glitch_empty", 32'(empty_a), 1);
    eq_a.push_back(32'd1);
    send(0, 8'h3C, -1, 1'b0);
    @(negedge clk);
    check("frame_err_empty", 32'(empty_a), 1);
    dq_a.push_back(8'h11);
    send(0, 8'h11, -1, 1'b1);
    read(0);
    eq_b.push_back(32'd2);
    send(1, 8'h03, 1, 1'b1);
    @(negedge clk);
    check("parity_err_empty", 32'(empty_b), 1);
    dq_b.push_back(8'h03);
    send(1, 8'h03, 0, 1'b1);
    @(negedge clk);
    check("parity_ok_level", 32'(level_b), 1);
    read(1);
    for (int i = 1; i <= 5; i++) begin
      if (i < 5) dq_a.push_back(8'(i));
      send(0, 8'(i), -1, 1'b1);
    end
    @(negedge clk);
    check("ovr_full", 32'(full_a), 1);
    check("ovr_set", 32'(ov_a), 1);
    check("ovr_level", 32'(level_a), 4);
    repeat (4) read(0);
    @(negedge clk);
    check("drain_empty", 32'(empty_a), 1);
    check("ovr_sticky", 32'(ov_a), 1);
    @(posedge clk);
    #1 clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
    @(negedge clk);
    check("ovr_cleared", 32'(ov_a), 0);
    for (int i = 6; i <= 9; i++) begin
      dq_a.push_back(8'(i));
      send(0, 8'(i), -1, 1'b1);
    end
    dq_a.push_back(8'h0A);
    fork
      send(0, 8'h0A, -1, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 rd_a = 1'b1;
        @(posedge clk);
        #1 rd_a = 1'b0;
      end
    join
    @(negedge clk);
    check("full_pop_push_ovr", 32'(ov_a), 0);
    check("full_pop_push_level", 32'(level_a), 4);
    repeat (4) read(0);
    dq_a.push_back(8'h77);
    send(0, 8'h77, -1, 1'b1);
    @(negedge clk);
    check("pre_reset_level", 32'(level_a), 1);
    put(0, 1'b0);
    put(0, 1'b0);
    put(0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    rxd_a = 1'b1;
    dq_a.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_empty", 32'(empty_a), 1);
    check("mid_rst_full", 32'(full_a), 0);
    check("mid_rst_level", 32'(level_a), 0);
    check("mid_rst_rd_data", 32'(data_a), 0);
    check("mid_rst_errs", 32'({fe_a, pe_a, ov_a}), 0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle_empty", 32'(empty_a), 1);
    dq_a.push_back(8'h5A);
    send(0, 8'h5A, -1, 1'b1);
    @(negedge clk);
    check("post_rst_level", 32'(level_a), 1);
    read(0);
    repeat (5) @(posedge clk);
    check("dq_a_drained", 32'(dq_a.size()), 0);
    check("dq_b_drained", 32'(dq_b.size()), 0);
    check("eq_a_drained", 32'(eq_a.size()), 0);
    check("eq_b_drained", 32'(eq_b.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
